// File: rtl/pwm_ramp_ctrl.sv
// Sequences period/duty updates for pwmGen: new period only on a PWM period boundary, duty ramped in STEP_US steps.
// Latency: period update at next period_tick after handshake; ramp = ceil(|delta|/STEP_US)*HOLD_PERIODS periods.
// Backpressure: one target in flight, cfg_ready low outside IDLE. Soft-start stepping built only with PWM_CTRL_SOFTSTART_EN.
module pwm_ramp_ctrl #(
    parameter int CLK_PERIOD      = 10,
    parameter int DATA_WIDTH      = 16,
    parameter int STEP_US         = 1,
    parameter int HOLD_PERIODS    = 4,
    parameter int RESET_PERIOD_US = 100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [DATA_WIDTH-1:0] cfg_period,
    input  logic [DATA_WIDTH-1:0] cfg_duty,
    output logic [DATA_WIDTH-1:0] pwmPeriod,
    output logic [DATA_WIDTH-1:0] pwmDutyCycle,
    output logic                  period_tick,
    output logic                  busy,
    output logic                  done
);

    localparam int CLKS_PER_US = 1000 / CLK_PERIOD;
    localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_US - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ALIGN, ST_RAMP} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [DATA_WIDTH-1:0] us_q, us_d;
    logic [DATA_WIDTH-1:0] per_q, per_d;
    logic [DATA_WIDTH-1:0] duty_q, duty_d;
    logic [DATA_WIDTH-1:0] tgt_per_q, tgt_per_d;
    logic [DATA_WIDTH-1:0] tgt_duty_q, tgt_duty_d;
    logic                  strobe, last_us, tick;

`ifdef PWM_CTRL_SOFTSTART_EN
    localparam int HW = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
    localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(STEP_US);

    logic [HW-1:0]         hold_q, hold_d;
    logic [DATA_WIDTH-1:0] diff, step_duty;
    logic                  up;

    // Saturating move toward target: never overshoots, never wraps.
    always_comb begin
        up        = tgt_duty_q > duty_q;
        diff      = up ? (tgt_duty_q - duty_q) : (duty_q - tgt_duty_q);
        step_duty = tgt_duty_q;
        if (diff > STEP) begin
            step_duty = up ? (duty_q + STEP) : (duty_q - STEP);
        end
    end
`endif

    // A zero period behaves as one microsecond so the timebase never stalls.
    assign strobe  = presc_q == PRESC_MAX;
    assign last_us = (per_q == '0) || (us_q == per_q - 1'b1);
    assign tick    = strobe && last_us;

    always_comb begin
        presc_d    = strobe ? '0 : presc_q + 1'b1;
        us_d       = us_q;
        if (strobe) begin
            us_d = last_us ? '0 : us_q + 1'b1;
        end
        state_d    = state_q;
        per_d      = per_q;
        duty_d     = duty_q;
        tgt_per_d  = tgt_per_q;
        tgt_duty_d = tgt_duty_q;
`ifdef PWM_CTRL_SOFTSTART_EN
        hold_d     = hold_q;
`endif
        if (!enable) begin
            state_d = ST_IDLE;
            duty_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        tgt_per_d  = cfg_period;
                        tgt_duty_d = (cfg_duty > cfg_period) ? cfg_period : cfg_duty;
                        state_d    = ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    if (tick) begin
                        per_d   = tgt_per_q;
                        us_d    = '0;
                        presc_d = '0;
`ifdef PWM_CTRL_SOFTSTART_EN
                        hold_d  = '0;
                        duty_d  = (duty_q > tgt_per_q) ? tgt_per_q : duty_q;
`else
                        duty_d  = tgt_duty_q;
`endif
                        state_d = ST_RAMP;
                    end
                end
                ST_RAMP: begin
                    if (duty_q == tgt_duty_q) begin
                        state_d = ST_IDLE;
                    end
`ifdef PWM_CTRL_SOFTSTART_EN
                    else if (tick) begin
                        if (hold_q == HW'(HOLD_PERIODS - 1)) begin
                            hold_d = '0;
                            duty_d = step_duty;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            us_q       <= '0;
            per_q      <= DATA_WIDTH'(RESET_PERIOD_US);
            duty_q     <= '0;
            tgt_per_q  <= '0;
            tgt_duty_q <= '0;
`ifdef PWM_CTRL_SOFTSTART_EN
            hold_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            us_q       <= us_d;
            per_q      <= per_d;
            duty_q     <= duty_d;
            tgt_per_q  <= tgt_per_d;
            tgt_duty_q <= tgt_duty_d;
`ifdef PWM_CTRL_SOFTSTART_EN
            hold_q     <= hold_d;
`endif
        end
    end

    assign pwmPeriod    = per_q;
    assign pwmDutyCycle = duty_q;
    assign period_tick  = rst_n && tick;
    assign busy         = state_q != ST_IDLE;
    assign cfg_ready    = rst_n && enable && (state_q == ST_IDLE);
    assign done         = rst_n && enable && (state_q == ST_RAMP) && (duty_q == tgt_duty_q);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed target table, corner sequences and randomized traffic against a clock-level reference.
module tb_pwm_ramp_ctrl;

    localparam int CLKP = 250;
    localparam int NCLK = 1000 / CLKP;
    localparam int DW   = 16;
    localparam int STEP = 2;
    localparam int HOLD = 2;
    localparam int RSTP = 20;

    logic          clk = 1'b0;
    logic          rst_n, enable, cfg_valid;
    logic [DW-1:0] cfg_period, cfg_duty;
    logic          cfg_ready, period_tick, busy, done;
    logic [DW-1:0] pwmPeriod, pwmDutyCycle;

    int n_cmp = 0;
    int n_bad = 0;

    pwm_ramp_ctrl #(
        .CLK_PERIOD(CLKP), .DATA_WIDTH(DW), .STEP_US(STEP),
        .HOLD_PERIODS(HOLD), .RESET_PERIOD_US(RSTP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_period(cfg_period), .cfg_duty(cfg_duty),
        .pwmPeriod(pwmPeriod), .pwmDutyCycle(pwmDutyCycle),
        .period_tick(period_tick), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        #3;
    endtask

    // ---------------- reference model ----------------
    // Timebase as one clock-phase counter over a whole period; duty after alignment
    // is a closed form of the ticks elapsed since the boundary.
    bit m_valid = 0, m_busy = 0, m_aligned = 0;
    int m_per = RSTP, m_duty = 0, m_phase = 0, m_tper = 0, m_tduty = 0, m_d0 = 0, m_k = 0;

    function automatic int approach(int d0, int t, int amt);
        if (t >= d0) return (t - d0 <= amt) ? t : d0 + amt;
        return (d0 - t <= amt) ? t : d0 - amt;
    endfunction

    function automatic int per_clks(int p);
        return NCLK * ((p == 0) ? 1 : p);
    endfunction

    task automatic model_step();
        bit tk;
        if (!rst_n) begin
            m_valid = 1; m_busy = 0; m_aligned = 0;
            m_per = RSTP; m_duty = 0; m_phase = 0;
        end else if (m_valid) begin
            tk = (m_phase == per_clks(m_per) - 1);
            m_phase = tk ? 0 : m_phase + 1;
            if (!enable) begin
                m_busy = 0;
                m_duty = 0;
            end else if (!m_busy) begin
                if (cfg_valid) begin
                    m_busy = 1; m_aligned = 0;
                    m_tper = int'(cfg_period);
                    m_tduty = (cfg_duty > cfg_period) ? int'(cfg_period) : int'(cfg_duty);
                end
            end else if (!m_aligned) begin
                if (tk) begin
                    m_per = m_tper; m_aligned = 1; m_k = 0;
`ifdef PWM_CTRL_SOFTSTART_EN
                    m_d0 = (m_duty > m_tper) ? m_tper : m_duty;
`else
                    m_d0 = m_tduty;
`endif
                    m_duty = m_d0;
                end
            end else if (m_duty == m_tduty) begin
                m_busy = 0;
            end else if (tk) begin
                m_k++;
                m_duty = approach(m_d0, m_tduty, STEP * (m_k / HOLD));
            end
        end
    endtask

    initial begin : monitor
        logic [DW-1:0] e_per, e_duty;
        logic e_tick, e_busy, e_done, e_rdy;
        forever begin
            @(negedge clk);
            #2;
            if (m_valid) begin
                e_per  = DW'(m_per);
                e_duty = DW'(m_duty);
                e_tick = rst_n && (m_phase == per_clks(m_per) - 1);
                e_busy = m_busy;
                e_rdy  = rst_n && enable && !m_busy;
                e_done = rst_n && enable && m_busy && m_aligned && (m_duty == m_tduty);
                n_cmp++;
                if ({pwmPeriod, pwmDutyCycle, period_tick, busy, done, cfg_ready} !==
                    {e_per, e_duty, e_tick, e_busy, e_done, e_rdy}) begin
                    n_bad++;
                    $display("FAIL cycle_model t=%0t: got per=%0d duty=%0d tick=%b busy=%b done=%b rdy=%b, expected per=%0d duty=%0d tick=%b busy=%b done=%b rdy=%b",
                             $time, pwmPeriod, pwmDutyCycle, period_tick, busy, done, cfg_ready,
                             e_per, e_duty, e_tick, e_busy, e_done, e_rdy);
                end
            end
            @(posedge clk);
            model_step();
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    typedef struct {
        int per; int duty; int exp_per;
        int align_ss; int align_imm; int ticks_ss; int final_d;
    } vec_t;

    task automatic handshake(input int p, input int d);
        int w = 0;
        while (!cfg_ready && w < 2000) begin nxt(); w++; end
        chk("ready_before_cfg", cfg_ready, 1);
        cfg_valid = 1; cfg_period = DW'(p); cfg_duty = DW'(d);
        nxt();
        cfg_valid = 0;
    endtask

    task automatic wait_boundary();
        int w = 0;
        while (!period_tick && w < 2000) begin nxt(); w++; end
        chk("tick_seen", period_tick, 1);
        nxt();
    endtask

    initial begin : stim
        vec_t tbl[6];
        int cnt, ticks, w, exp_align, exp_ticks;

        tbl[0] = '{10, 3,  10, 0,  3,  4, 3};
        tbl[1] = '{10, 25, 10, 3,  10, 8, 10};
        tbl[2] = '{8,  2,  8,  8,  2,  6, 2};
        tbl[3] = '{8,  2,  8,  2,  2,  0, 2};
        tbl[4] = '{0,  5,  0,  0,  0,  0, 0};
        tbl[5] = '{12, 0,  12, 0,  0,  0, 0};

        rst_n = 0; enable = 0; cfg_valid = 0; cfg_period = '0; cfg_duty = '0;
        repeat (3) nxt();
        enable = 1;
        #1;
        chk("rst_period", pwmPeriod, RSTP);
        chk("rst_duty", pwmDutyCycle, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tick", period_tick, 0);
        chk("rst_ready", cfg_ready, 0);

        rst_n = 1;
        cnt = 0;
        while (!period_tick && cnt < 1000) begin nxt(); cnt++; end
        chk("first_tick_clks", cnt, NCLK * RSTP - 1);

        for (int i = 0; i < 6; i++) begin
`ifdef PWM_CTRL_SOFTSTART_EN
            exp_align = tbl[i].align_ss;  exp_ticks = tbl[i].ticks_ss;
`else
            exp_align = tbl[i].align_imm; exp_ticks = 0;
`endif
            handshake(tbl[i].per, tbl[i].duty);
            chk($sformatf("v%0d_busy_hs", i), busy, 1);
            chk($sformatf("v%0d_ready_hs", i), cfg_ready, 0);
            wait_boundary();
            chk($sformatf("v%0d_align_per", i), pwmPeriod, tbl[i].exp_per);
            chk($sformatf("v%0d_align_duty", i), pwmDutyCycle, exp_align);
            ticks = 0; w = 0;
            while (!done && w < 5000) begin
                if (period_tick) ticks++;
                nxt(); w++;
            end
            chk($sformatf("v%0d_done", i), done, 1);
            chk($sformatf("v%0d_ramp_ticks", i), ticks, exp_ticks);
            chk($sformatf("v%0d_final_duty", i), pwmDutyCycle, tbl[i].final_d);
            nxt();
            chk($sformatf("v%0d_busy_end", i), busy, 0);
            chk($sformatf("v%0d_done_1clk", i), done, 0);
        end

        // Abort while waiting for the boundary: period must stay untouched.
        handshake(16, 14);
        enable = 0;
        nxt();
        chk("abort_align_per", pwmPeriod, 12);
        chk("abort_align_duty", pwmDutyCycle, 0);
        chk("abort_align_busy", busy, 0);
        enable = 1;
        #1;
        chk("abort_align_reready", cfg_ready, 1);

`ifdef PWM_CTRL_SOFTSTART_EN
        // Abort mid-ramp at duty 4.
        handshake(16, 14);
        w = 0;
        while (pwmDutyCycle != 4 && w < 5000) begin nxt(); w++; end
        chk("abort_ramp_reached", pwmDutyCycle, 4);
        enable = 0;
        nxt();
        chk("abort_ramp_duty", pwmDutyCycle, 0);
        chk("abort_ramp_busy", busy, 0);
        chk("abort_ramp_done", done, 0);
        chk("abort_ramp_per", pwmPeriod, 16);
        enable = 1;
        #1;
        chk("abort_ramp_reready", cfg_ready, 1);
`endif

        // Offers while disabled are ignored.
        enable = 0; cfg_valid = 1; cfg_period = 9; cfg_duty = 4;
        repeat (5) nxt();
        chk("dis_ready", cfg_ready, 0);
        chk("dis_busy", busy, 0);
        cfg_valid = 0; enable = 1;
        nxt();

        // Reset in the middle of a transaction.
        handshake(10, 9);
        wait_boundary();
        chk("mid_rst_pre_per", pwmPeriod, 10);
        rst_n = 0;
        nxt();
        chk("mid_rst_per", pwmPeriod, RSTP);
        chk("mid_rst_duty", pwmDutyCycle, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", cfg_ready, 0);
        rst_n = 1;
        nxt();

        // Randomized traffic, checked cycle by cycle by the monitor.
        for (int c = 0; c < 6000; c++) begin
            enable     = ($urandom_range(0, 599) != 0);
            rst_n      = ($urandom_range(0, 1999) != 0);
            cfg_valid  = ($urandom_range(0, 3) == 0);
            cfg_period = DW'($urandom_range(0, 14));
            cfg_duty   = DW'($urandom_range(0, 18));
            nxt();
        end
        cfg_valid = 0; rst_n = 1; enable = 1;
        repeat (4) nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
